// File: rtl/weight_guard.sv
`default_nettype none
// ============================================================================
//  Module   : weight_guard
//  Purpose  : Debounced warn/overload classifier with hysteresis for cabin
//             load-cell samples; door-hold request and saturating event count.
//             Optional moving-average front end enabled by WEIGHT_AVG_EN.
//  Revision : 1.0  initial release
// ============================================================================
module weight_guard #(
    parameter int W_WIDTH    = 12,
    parameter int LIMIT      = 800,
    parameter int WARN_LEVEL = 720,
    parameter int HYST       = 40,
    parameter int DEBOUNCE   = 4,
    parameter int AVG_LOG2   = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sample_valid,
    input  logic [W_WIDTH-1:0] sample,
    input  logic               clear,
    output logic [W_WIDTH-1:0] weight_value,
    output logic               weight_warn,
    output logic               weight_limit_exceeded,
    output logic               door_hold,
    output logic [1:0]         state,
    output logic [7:0]         overload_count
);

    localparam int c_CNT_W = $clog2(DEBOUNCE + 1);
    localparam int c_CMP_W = W_WIDTH + 1;

    localparam logic [c_CMP_W-1:0] c_LIMIT    = c_CMP_W'(LIMIT);
    localparam logic [c_CMP_W-1:0] c_WARN     = c_CMP_W'(WARN_LEVEL);
    localparam logic [c_CMP_W-1:0] c_WARN_REL = c_CMP_W'(WARN_LEVEL - HYST);
    localparam logic [c_CMP_W-1:0] c_OVER_REL = c_CMP_W'(LIMIT - HYST);
    localparam logic [c_CNT_W-1:0] c_DEB      = c_CNT_W'(DEBOUNCE);

    localparam logic [1:0] c_ST_OK   = 2'b00;
    localparam logic [1:0] c_ST_WARN = 2'b01;
    localparam logic [1:0] c_ST_OVER = 2'b10;

    generate
        if (WARN_LEVEL > LIMIT || HYST > WARN_LEVEL || DEBOUNCE == 0 || AVG_LOG2 < 0) begin : g_param_err
            $error("weight_guard: illegal parameter combination");
        end
    endgenerate

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic [c_CNT_W-1:0] w_cnt_inc;
    logic [7:0]         r_ovl_cnt;
    logic [7:0]         w_ovl_nxt;
    logic [W_WIDTH-1:0] r_value;
    logic [W_WIDTH-1:0] w_v;
    logic [c_CMP_W-1:0] w_v_ext;

`ifdef WEIGHT_AVG_EN
    localparam int c_N     = 1 << AVG_LOG2;
    localparam int c_SUM_W = W_WIDTH + AVG_LOG2;

    logic [c_SUM_W-1:0] w_sum;

    generate
        if (c_N > 1) begin : g_avg_buf
            // History holds the previous c_N-1 accepted samples; the current one is added live.
            logic [W_WIDTH-1:0] r_hist [c_N-1];

            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int i = 0; i < c_N - 1; i++) r_hist[i] <= '0;
                end else if (sample_valid && !clear) begin
                    r_hist[0] <= sample;
                    for (int i = 1; i < c_N - 1; i++) r_hist[i] <= r_hist[i-1];
                end
            end

            always_comb begin
                w_sum = c_SUM_W'(sample);
                for (int i = 0; i < c_N - 1; i++) w_sum = w_sum + c_SUM_W'(r_hist[i]);
            end
        end else begin : g_avg_pass
            assign w_sum = c_SUM_W'(sample);
        end
    endgenerate

    assign w_v = W_WIDTH'(w_sum >> AVG_LOG2);
`else
    assign w_v = sample;
`endif

    assign w_v_ext   = {1'b0, w_v};
    assign w_cnt_inc = r_cnt + c_CNT_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_ST_OK;
            r_cnt     <= '0;
            r_ovl_cnt <= '0;
            r_value   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_ovl_cnt <= w_ovl_nxt;
            if (sample_valid && !clear) r_value <= w_v;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_ovl_nxt   = r_ovl_cnt;
        if (clear) begin
            w_state_nxt = c_ST_OK;
            w_cnt_nxt   = '0;
        end else if (sample_valid) begin
            case (r_state)
                c_ST_OK, c_ST_WARN: begin
                    if (w_v_ext > c_LIMIT) begin
                        if (w_cnt_inc == c_DEB) begin
                            w_state_nxt = c_ST_OVER;
                            w_cnt_nxt   = '0;
                            if (r_ovl_cnt != 8'hFF) w_ovl_nxt = r_ovl_cnt + 8'd1;
                        end else begin
                            w_cnt_nxt = w_cnt_inc;
                        end
                    end else begin
                        w_cnt_nxt = '0;
                        if (r_state == c_ST_OK && w_v_ext >= c_WARN)
                            w_state_nxt = c_ST_WARN;
                        else if (r_state == c_ST_WARN && w_v_ext < c_WARN_REL)
                            w_state_nxt = c_ST_OK;
                    end
                end
                c_ST_OVER: begin
                    if (w_v_ext < c_OVER_REL) begin
                        if (w_cnt_inc == c_DEB) begin
                            w_state_nxt = (w_v_ext >= c_WARN_REL) ? c_ST_WARN : c_ST_OK;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_cnt_nxt = w_cnt_inc;
                        end
                    end else begin
                        w_cnt_nxt = '0;
                    end
                end
                default: begin
                    // Unreachable encoding recovers to OK.
                    w_state_nxt = c_ST_OK;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    assign state                 = r_state;
    assign weight_value          = r_value;
    assign overload_count        = r_ovl_cnt;
    assign weight_warn           = (r_state == c_ST_WARN) || (r_state == c_ST_OVER);
    assign weight_limit_exceeded = (r_state == c_ST_OVER);
    assign door_hold             = (r_state == c_ST_OVER);

endmodule
`default_nettype wire

// File: tb/tb_weight_guard.sv
`default_nettype none
// ============================================================================
//  Module   : tb_weight_guard
//  Purpose  : Scoreboard bench for weight_guard; directed vectors with
//             hand-computed expectations (WEIGHT_AVG_EN selects the avg set).
//  Revision : 1.0  initial release
// ============================================================================
module tb_weight_guard;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        sample_valid = 1'b0;
    logic [11:0] sample = '0;
    logic        clear = 1'b0;
    logic [11:0] weight_value;
    logic        weight_warn;
    logic        weight_limit_exceeded;
    logic        door_hold;
    logic [1:0]  state;
    logic [7:0]  overload_count;

    typedef struct {
        logic [1:0]  st;
        logic [7:0]  cnt;
        logic [11:0] val;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_err    = 0;

    weight_guard dut (
        .clk                  (clk),
        .reset                (reset),
        .sample_valid         (sample_valid),
        .sample               (sample),
        .clear                (clear),
        .weight_value         (weight_value),
        .weight_warn          (weight_warn),
        .weight_limit_exceeded(weight_limit_exceeded),
        .door_hold            (door_hold),
        .state                (state),
        .overload_count       (overload_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Any cycle carrying reset, a sample or a clear produces a response one edge later.
    always @(posedge clk) begin
        if (reset || sample_valid || clear) begin
            #1;
            if (q.size() == 0) begin
                chk("scoreboard_underflow", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("state", int'(state), int'(e.st));
                chk("overload_count", int'(overload_count), int'(e.cnt));
                chk("weight_value", int'(weight_value), int'(e.val));
                chk("weight_warn", int'(weight_warn), int'(e.st != 2'b00));
                chk("limit_exceeded", int'(weight_limit_exceeded), int'(e.st == 2'b10));
                chk("door_hold", int'(door_hold), int'(e.st == 2'b10));
            end
        end
    end

    task automatic step(input logic v, input int s, input logic c, input logic r,
                        input int est, input int ecnt, input int eval);
        exp_t e;
        @(negedge clk);
        sample_valid = v;
        sample       = 12'(s);
        clear        = c;
        reset        = r;
        if (v || c || r) begin
            e.st  = 2'(est);
            e.cnt = 8'(ecnt);
            e.val = 12'(eval);
            q.push_back(e);
        end
    endtask

    task automatic smp(input int s, input int est, input int ecnt, input int eval);
        step(1'b1, s, 1'b0, 1'b0, est, ecnt, eval);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int c;
        step(1'b0, 0, 1'b0, 1'b1, 0, 0, 0);
        step(1'b0, 0, 1'b0, 1'b1, 0, 0, 0);
`ifdef WEIGHT_AVG_EN
        smp(1000, 0, 0, 250);
        smp(1000, 0, 0, 500);
        smp(1000, 1, 0, 750);
        smp(1000, 1, 0, 1000);
        step(1'b1, 0, 1'b1, 1'b0, 0, 0, 1000);  // discarded sample must not enter the average
        smp(1000, 0, 0, 1000);
        smp(1000, 0, 0, 1000);
        smp(1000, 0, 0, 1000);
        smp(1000, 2, 1, 1000);
`else
        smp(700, 0, 0, 700);
        smp(730, 1, 0, 730);
        smp(690, 1, 0, 690);
        smp(679, 0, 0, 679);
        for (int i = 0; i < 3; i++) smp(850, 0, 0, 850);
        smp(790, 1, 0, 790);
        for (int i = 0; i < 3; i++) smp(850, 1, 0, 850);
        smp(850, 2, 1, 850);
        step(1'b1, 900, 1'b1, 1'b0, 0, 1, 850);
        for (int i = 0; i < 3; i++) smp(900, 0, 1, 900);
        smp(900, 2, 2, 900);
        for (int i = 0; i < 4; i++) smp(770, 2, 2, 770);
        for (int i = 0; i < 3; i++) smp(750, 2, 2, 750);
        smp(750, 1, 2, 750);
        smp(850, 1, 2, 850);
        smp(850, 1, 2, 850);
        step(1'b0, 0, 1'b0, 1'b0, 0, 0, 0);
        step(1'b0, 0, 1'b0, 1'b0, 0, 0, 0);
        smp(850, 1, 2, 850);
        smp(850, 2, 3, 850);
        smp(0, 2, 3, 0);
        smp(0, 2, 3, 0);
        step(1'b1, 0, 1'b0, 1'b1, 0, 0, 0);
        smp(0, 0, 0, 0);
        for (int i = 0; i < 4; i++) smp(800, 1, 0, 800);
        for (int i = 0; i < 3; i++) smp(801, 1, 0, 801);
        smp(801, 2, 1, 801);
        step(1'b0, 0, 1'b1, 1'b0, 0, 1, 801);
        for (int i = 0; i < 3; i++) smp(801, 0, 1, 801);
        smp(801, 2, 2, 801);
        for (int i = 0; i < 4; i++) smp(760, 2, 2, 760);
        for (int i = 0; i < 3; i++) smp(759, 2, 2, 759);
        smp(759, 1, 2, 759);
        smp(0, 0, 2, 0);
        c = 2;
        for (int n = 0; n < 260; n++) begin
            for (int i = 0; i < 3; i++) smp(900, 0, c, 900);
            c = (c < 255) ? c + 1 : 255;
            smp(900, 2, c, 900);
            for (int i = 0; i < 3; i++) smp(0, 2, c, 0);
            smp(0, 0, c, 0);
        end
`endif
        step(1'b0, 0, 1'b0, 1'b0, 0, 0, 0);
        step(1'b0, 0, 1'b0, 1'b0, 0, 0, 0);
        chk("queue_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
